// File: rtl/port_uart_tx.sv
// port_uart_tx: 8N1 serial transmitter behind the F0 (data), F1 (req toggle) and F8 (status) ports.
// Build with PORT_UART_TX_PARITY_EN defined to insert an even-parity bit before the stop bit.
module port_uart_tx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic [7:0] tx_ctrl,
   output logic [7:0] tx_status,
   output logic       txd
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef PORT_UART_TX_PARITY_EN
   localparam logic PAR_BUILT = 1'b1;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   localparam logic PAR_BUILT = 1'b0;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t          state_q;
   state_t          state_d;
   logic [CW-1:0]   baud_q;
   logic [2:0]      bit_q;
   logic [7:0]      shift_q;
   logic [7:0]      hold_q;
   logic            full_q;
   logic            ack_q;
   logic            txd_q;
   logic            txd_d;
   logic            baud_end;
   logic            load;
   logic            pending;
   logic            accept;
   logic            unused_ctrl;
`ifdef PORT_UART_TX_PARITY_EN
   logic            parity_q;
`endif

   assign unused_ctrl = ^tx_ctrl[7:1];
   assign baud_end    = (baud_q == BAUD_LAST);
   assign pending     = tx_ctrl[0] ^ ack_q;
   // A load frees the holding register on the same edge, so a request can land then too.
   assign accept      = pending && (!full_q || load);

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
         IDLE: begin
            if (full_q) begin
               load    = 1'b1;
               state_d = START;
            end
         end
         START: begin
            if (baud_end) state_d = DATA;
         end
         DATA: begin
            if (baud_end && (bit_q == 3'd7)) begin
`ifdef PORT_UART_TX_PARITY_EN
               state_d = PARITY;
`else
               state_d = STOP;
`endif
            end
         end
`ifdef PORT_UART_TX_PARITY_EN
         PARITY: begin
            if (baud_end) state_d = STOP;
         end
`endif
         STOP: begin
            if (baud_end) begin
               if (full_q) begin
                  load    = 1'b1;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      txd_d = 1'b1;
      case (state_q)
         START:   txd_d = 1'b0;
         DATA:    txd_d = shift_q[0];
`ifdef PORT_UART_TX_PARITY_EN
         PARITY:  txd_d = parity_q;
`endif
         default: txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
         hold_q  <= 8'h00;
         full_q  <= 1'b0;
         ack_q   <= 1'b0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         txd_q   <= txd_d;
         if (accept) begin
            hold_q <= tx_data;
            ack_q  <= tx_ctrl[0];
            full_q <= 1'b1;
         end else if (load) begin
            full_q <= 1'b0;
         end
         if (load) begin
            shift_q <= hold_q;
            bit_q   <= 3'd0;
            baud_q  <= '0;
         end else if (state_q != IDLE) begin
            baud_q <= baud_end ? '0 : baud_q + CW'(1);
            if ((state_q == DATA) && baud_end) begin
               shift_q <= {1'b0, shift_q[7:1]};
               bit_q   <= bit_q + 3'd1;
            end
         end
      end
   end

`ifdef PORT_UART_TX_PARITY_EN
   // Parity is taken from the byte at load time because the shifter is consumed bit by bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parity_q <= 1'b0;
      end else if (load) begin
         parity_q <= ^hold_q;
      end
   end
`endif

   assign txd       = txd_q;
   assign tx_status = {4'b0000, PAR_BUILT, full_q, (state_q != IDLE), ack_q};

endmodule

// File: tb/tb_port_uart_tx.sv
// tb_port_uart_tx: scoreboard bench for port_uart_tx; bytes are queued on request and
// compared against frames decoded from txd by a mid-bit sampling monitor.
module tb_port_uart_tx;

   localparam int CPB = 4;
`ifdef PORT_UART_TX_PARITY_EN
   localparam int   NBITS   = 11;
   localparam logic PAR_EXP = 1'b1;
`else
   localparam int   NBITS   = 10;
   localparam logic PAR_EXP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic [7:0] tx_ctrl = 8'h00;
   logic [7:0] tx_status;
   logic       txd;
   logic       req = 1'b0;
   bit         mon_en = 1'b1;
   int         checks = 0;
   int         passed = 0;
   int         cycle = 0;
   logic [7:0] sb_q[$];
   int         starts[$];

   port_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tx_data   (tx_data),
      .tx_ctrl   (tx_ctrl),
      .tx_status (tx_status),
      .txd       (txd)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed == expected) passed++;
      else $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
   endtask

   task automatic applyStimulus(input logic [7:0] d, input bit track);
      @(negedge clk);
      tx_data = d;
      req     = ~req;
      tx_ctrl = {7'b0, req};
      if (track) sb_q.push_back(d);
   endtask

   task automatic waitAck(input string tag);
      int got = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (tx_status[0] == req) begin
            got = 1;
            break;
         end
      end
      checkOutput(tag, got, 1);
   endtask

   task automatic waitIdle(input string tag);
      int got = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (tx_status[1] == 1'b0) begin
            got = 1;
            break;
         end
      end
      checkOutput(tag, got, 1);
      repeat (2 * CPB) @(negedge clk);
   endtask

   // Frame decoder: start detected on a low sample, then each bit sampled near its middle.
   initial begin : monitor
      logic [NBITS-1:0] bits;
      logic [7:0]       exp_byte;
      forever begin
         @(negedge clk);
         if (mon_en && rst_n && txd == 1'b0) begin
            starts.push_back(cycle);
            for (int k = 0; k < NBITS; k++) begin
               repeat ((k == 0) ? CPB / 2 : CPB) @(negedge clk);
               bits[k] = txd;
            end
            if (sb_q.size() == 0) begin
               checkOutput("unexpected_frame", 1, 0);
            end else begin
               exp_byte = sb_q.pop_front();
               checkOutput("frame_start", int'(bits[0]), 0);
               checkOutput("frame_data", int'(bits[8:1]), int'(exp_byte));
`ifdef PORT_UART_TX_PARITY_EN
               checkOutput("frame_parity", int'(bits[9]), int'(^exp_byte));
`endif
               checkOutput("frame_stop", int'(bits[NBITS-1]), 1);
            end
            repeat (CPB - CPB / 2 - 1) @(negedge clk);
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] simulation time limit reached");
   end

   initial begin : main
      int lows;

      // Reset state and quiet line after release
      #12;
      checkOutput("reset_txd", int'(txd), 1);
      checkOutput("reset_status", int'(tx_status), int'({4'b0, PAR_EXP, 3'b000}));
      @(negedge clk);
      rst_n = 1'b1;
      lows = 0;
      repeat (20) begin
         @(negedge clk);
         if (txd == 1'b0) lows++;
      end
      checkOutput("idle_txd_low_samples", lows, 0);

      // Single byte with ack one edge after the toggle
      applyStimulus(8'hA5, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("single_ack", int'(tx_status[0]), 1);
      checkOutput("single_full", int'(tx_status[2]), 1);
      repeat (CPB * 5) @(negedge clk);
      checkOutput("single_busy_mid", int'(tx_status[1]), 1);
      waitIdle("single_idle");
      checkOutput("single_sb_empty", sb_q.size(), 0);

      // Back-to-back frames must be contiguous
      starts.delete();
      applyStimulus(8'h00, 1'b1);
      waitAck("b2b_ack1");
      applyStimulus(8'hFF, 1'b1);
      waitAck("b2b_ack2");
      checkOutput("b2b_ack2_during_frame", int'(tx_status[1]), 1);
      waitIdle("b2b_idle");
      checkOutput("b2b_frames", starts.size(), 2);
      if (starts.size() == 2) checkOutput("b2b_gap", starts[1] - starts[0], NBITS * CPB);

      // Backpressure: third request waits for the second byte to load
      applyStimulus(8'h11, 1'b1);
      waitAck("bp_ack1");
      @(negedge clk);
      @(negedge clk);
      applyStimulus(8'h22, 1'b1);
      waitAck("bp_ack2");
      applyStimulus(8'h3C, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("bp_ack3_withheld", int'(tx_status[0] == req), 0);
      checkOutput("bp_full", int'(tx_status[2]), 1);
      repeat (8) @(negedge clk);
      checkOutput("bp_ack3_still_withheld", int'(tx_status[0] == req), 0);
      waitAck("bp_ack3");
      checkOutput("bp_busy_at_ack3", int'(tx_status[1]), 1);
      waitIdle("bp_idle");
      checkOutput("bp_sb_empty", sb_q.size(), 0);

`ifdef PORT_UART_TX_PARITY_EN
      applyStimulus(8'h07, 1'b1);
      waitIdle("par_idle_07");
      applyStimulus(8'h03, 1'b1);
      waitIdle("par_idle_03");
      checkOutput("par_flag", int'(tx_status[3]), 1);
`endif

      // Reset in the middle of data bit 3 of a zero byte
      mon_en = 1'b0;
      applyStimulus(8'h00, 1'b0);
      lows = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (txd == 1'b0) begin
            lows = 1;
            break;
         end
      end
      checkOutput("rst_frame_started", lows, 1);
      repeat (4 * CPB + 2) @(negedge clk);
      checkOutput("rst_txd_before", int'(txd), 0);
      rst_n   = 1'b0;
      req     = 1'b0;
      tx_ctrl = 8'h00;
      #1;
      checkOutput("rst_txd_immediate", int'(txd), 1);
      checkOutput("rst_status", int'(tx_status), int'({4'b0, PAR_EXP, 3'b000}));
      @(negedge clk);
      rst_n = 1'b1;
      lows = 0;
      repeat (100) begin
         @(negedge clk);
         if (txd == 1'b0) lows++;
      end
      checkOutput("rst_no_frame_after", lows, 0);
      checkOutput("rst_busy_after", int'(tx_status[1]), 0);
      checkOutput("final_sb_empty", sb_q.size(), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
